// File: rtl/receiver_corr_accum_if.sv
// Stream bundle between the product multiplier, the correlation
// accumulator and the next receiver stage. The slave modport is the
// accumulator's view; the master modport is the surrounding pipeline's.
interface receiver_corr_accum_if #(
  parameter int unsigned PROD_WIDTH = 33,
  parameter int unsigned OUT_WIDTH  = 24
);
  logic [PROD_WIDTH-1:0] prod_tdata;
  logic                  prod_tvalid;
  logic                  prod_tready;
  logic [OUT_WIDTH-1:0]  acc_tdata;
  logic                  acc_tvalid;
  logic                  acc_tready;
  logic                  sat_flag;

  modport master (
    output prod_tdata, prod_tvalid, acc_tready,
    input  prod_tready, acc_tdata, acc_tvalid, sat_flag
  );

  modport slave (
    input  prod_tdata, prod_tvalid, acc_tready,
    output prod_tready, acc_tdata, acc_tvalid, sat_flag
  );
endinterface

// File: rtl/receiver_corr_accum.sv
// Correlation / FIR accumulator: sums NUM_TAPS signed products, rounds
// half-up, shifts right by SHIFT, narrows to OUT_WIDTH and presents the
// sample on a valid/ready output.
// Optional build macro RECEIVER_ACC_SAT_EN: clamp out-of-range samples and
// raise sat_flag; without it the sample wraps and sat_flag stays 0.
module receiver_corr_accum #(
  parameter int unsigned PROD_WIDTH = 33,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned NUM_TAPS   = 64,
  parameter int unsigned SHIFT      = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  receiver_corr_accum_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_TAPS);

  localparam logic [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {S_ACCUM, S_ROUND, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdy_q, rdy_d;
  logic                   vld_q, vld_d;
  logic                   sat_q, sat_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;

  logic                   accept;
  logic                   last_beat;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH:0] rnd_sum;
  logic signed [ACC_WIDTH:0] rnd_r;
  logic [OUT_WIDTH-1:0]   nar_data;
  logic                   nar_sat;

  assign bus.prod_tready = rdy_q;
  assign bus.acc_tvalid  = vld_q;
  assign bus.acc_tdata   = data_q;
  assign bus.sat_flag    = sat_q;

  assign accept    = bus.prod_tvalid && rdy_q;
  assign last_beat = (cnt_q == CNT_W'(NUM_TAPS - 1));
  assign prod_ext  = {{(ACC_WIDTH - PROD_WIDTH){bus.prod_tdata[PROD_WIDTH-1]}}, bus.prod_tdata};

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      data_q  <= data_d;
    end
  end

  // Next-state: ACCUM until the last tap, one ROUND cycle, DRAIN until taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACCUM: if (accept && last_beat) state_d = S_ROUND;
      S_ROUND: state_d = S_DRAIN;
      S_DRAIN: if (vld_q && bus.acc_tready) state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  // Round half-up, arithmetic shift and narrowing of the finished sum
  always_comb begin
    rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + RND;
    rnd_r   = rnd_sum >>> SHIFT;
`ifdef RECEIVER_ACC_SAT_EN
    if (rnd_r > OUT_MAX) begin
      nar_data = OUT_WIDTH'(OUT_MAX);
      nar_sat  = 1'b1;
    end else if (rnd_r < OUT_MIN) begin
      nar_data = OUT_WIDTH'(OUT_MIN);
      nar_sat  = 1'b1;
    end else begin
      nar_data = OUT_WIDTH'(rnd_r);
      nar_sat  = 1'b0;
    end
`else
    nar_data = OUT_WIDTH'(rnd_r);
    nar_sat  = 1'b0;
`endif
  end

  // Outputs and datapath updates per state; ready is registered from the
  // next state so it never depends combinationally on valid or acc_tready
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    sat_d  = sat_q;
    data_d = data_q;
    rdy_d  = (state_d == S_ACCUM);
    unique case (state_q)
      S_ACCUM: begin
        if (accept) begin
          acc_d = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
        end
      end
      S_ROUND: begin
        data_d = nar_data;
        sat_d  = nar_sat;
        vld_d  = 1'b1;
      end
      S_DRAIN: begin
        if (vld_q && bus.acc_tready) begin
          vld_d = 1'b0;
          sat_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_receiver_corr_accum.sv
// Self-checking bench for receiver_corr_accum: table-driven frames with a
// scoreboard queue, plus hand-written latency, backpressure and reset cases.
module tb_receiver_corr_accum;

  localparam int PW = 33;
  localparam int OW = 24;
  localparam int NT = 64;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  receiver_corr_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

  receiver_corr_accum #(
    .PROD_WIDTH(PW), .ACC_WIDTH(40), .OUT_WIDTH(OW), .NUM_TAPS(NT), .SHIFT(15)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string  name;
    longint data;
    bit     sat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string  name;
    longint first;
    longint rest;
    longint exp_data;
    bit     exp_sat;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard consumer: compare each sample at its handshake
  always @(negedge ap_clk) begin
    if (!ap_rst && bus.acc_tvalid && bus.acc_tready) begin
      if (sb.size() == 0) begin
        check("spurious_sample", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("%s acc_tdata", e.name), longint'($signed(bus.acc_tdata)), e.data);
        check($sformatf("%s sat_flag", e.name), longint'(bus.sat_flag), longint'(e.sat));
      end
    end
  end

  // Present one beat, optionally after random idle cycles; returns at posedge+1
  task automatic drive_beat(input longint v, input int gap_pct);
    int n = 0;
    int guard = 0;
    logic rd;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && n < 8) begin
      bus.prod_tvalid = 1'b0;
      @(posedge ap_clk); #1;
      n++;
    end
    bus.prod_tvalid = 1'b1;
    bus.prod_tdata  = PW'(v);
    do begin
      rd = bus.prod_tready;
      @(posedge ap_clk); #1;
      guard++;
    end while (!rd && guard < 200);
    if (!rd) check("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input string name, input longint first, input longint rest,
                            input int nbeats, input int gap_pct, input bit push,
                            input longint exp_data, input bit exp_sat, input bit chk_lat);
    if (push) sb.push_back('{name, exp_data, exp_sat});
    for (int i = 0; i < nbeats; i++) drive_beat((i == 0) ? first : rest, gap_pct);
    bus.prod_tvalid = 1'b0;
    if (chk_lat) begin
      check({name, " round_tvalid"}, longint'(bus.acc_tvalid), 0);
      check({name, " round_tready"}, longint'(bus.prod_tready), 0);
      @(posedge ap_clk); #1;
      check({name, " lat_tvalid"}, longint'(bus.acc_tvalid), 1);
    end
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while (sb.size() > 0 && g < 400) begin
      @(posedge ap_clk); #1;
      g++;
    end
    check({name, " drain_timeout"}, longint'(sb.size()), 0);
    @(posedge ap_clk); #1;
  endtask

  initial begin
    vecs[0] = '{"unity",    32768,  32768, 64, 1'b0};
    vecs[1] = '{"rnd_pos",  16384,  0,     1,  1'b0};
    vecs[2] = '{"rnd_neg",  -16384, 0,     0,  1'b0};
    vecs[3] = '{"rnd_neg2", -49152, 0,     -1, 1'b0};
`ifdef RECEIVER_ACC_SAT_EN
    vecs[4] = '{"sat", 64'h0_FFFF_FFFF, 64'h0_FFFF_FFFF, 8388607, 1'b1};
`else
    vecs[4] = '{"sat", 64'h0_FFFF_FFFF, 64'h0_FFFF_FFFF, -8388608, 1'b0};
`endif

    bus.prod_tvalid = 1'b0;
    bus.prod_tdata  = '0;
    bus.acc_tready  = 1'b1;

    // Reset held 3 cycles
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst prod_tready", longint'(bus.prod_tready), 0);
    check("rst acc_tvalid",  longint'(bus.acc_tvalid), 0);
    check("rst acc_tdata",   longint'(bus.acc_tdata), 0);
    check("rst sat_flag",    longint'(bus.sat_flag), 0);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("post_rst prod_tready", longint'(bus.prod_tready), 1);

    // Unity frame: latency and single-cycle valid pulse
    send_frame("unity_lat", 32768, 32768, NT, 0, 1'b1, 64, 1'b0, 1'b1);
    @(posedge ap_clk); #1;
    check("unity pulse_low", longint'(bus.acc_tvalid), 0);
    check("unity ready_back", longint'(bus.prod_tready), 1);
    wait_drain("unity_lat");

    // Table: gap-free then 50% random gaps, same expectations
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        send_frame($sformatf("%s_p%0d", vecs[i].name, pass), vecs[i].first, vecs[i].rest,
                   NT, (pass == 0) ? 0 : 50, 1'b1, vecs[i].exp_data, vecs[i].exp_sat,
                   pass == 0);
        wait_drain(vecs[i].name);
      end
    end

    // Backpressure: sample held 10 cycles, no products accepted
    bus.acc_tready = 1'b0;
    send_frame("bp", 32768, 32768, NT, 0, 1'b1, 64, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge ap_clk); #1;
      check("bp hold_data", longint'($signed(bus.acc_tdata)), 64);
      check("bp hold_valid", longint'(bus.acc_tvalid), 1);
      check("bp prod_tready", longint'(bus.prod_tready), 0);
    end
    bus.acc_tready = 1'b1;
    wait_drain("bp");
    send_frame("bp_next", 32768, 32768, NT, 0, 1'b1, 64, 1'b0, 1'b0);
    wait_drain("bp_next");

    // Mid-frame reset: the 30-beat partial frame must leave no residue
    send_frame("partial", 1048576, 1048576, 30, 0, 1'b0, 0, 1'b0, 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    check("midrst prod_tready", longint'(bus.prod_tready), 0);
    ap_rst = 1'b0;
    send_frame("after_rst", 32768, 32768, NT, 0, 1'b1, 64, 1'b0, 1'b0);
    wait_drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
